// File: rtl/brq_idu_multdiv_issue.sv
// brq_idu_multdiv_issue: issue/writeback controller for the iterative mul/div unit.
// Optional zero-operand fast path enabled by defining BRQ_MULTDIV_ZERO_FASTPATH_EN.
module brq_idu_multdiv_issue (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_is_div_i,
    input  logic [1:0]  req_operator_i,
    input  logic [1:0]  req_signed_mode_i,
    input  logic [31:0] req_op_a_i,
    input  logic [31:0] req_op_b_i,
    input  logic [4:0]  req_rd_i,
    input  logic        data_ind_timing_i,
    input  logic        flush_i,
    input  logic        wb_ready_i,
    output logic        mult_en_o,
    output logic        div_en_o,
    output logic        mult_sel_o,
    output logic        div_sel_o,
    output logic [1:0]  operator_o,
    output logic [1:0]  signed_mode_o,
    output logic [31:0] op_a_o,
    output logic [31:0] op_b_o,
    output logic [33:0] imd_val_q_o [2],
    input  logic [33:0] imd_val_d_i [2],
    input  logic [1:0]  imd_val_we_i,
    input  logic        md_valid_i,
    input  logic [31:0] md_result_i,
    output logic        multdiv_ready_id_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        busy_o
);
`ifdef BRQ_MULTDIV_ZERO_FASTPATH_EN
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, FAST} state_e;
    typedef enum logic [1:0] {MD_OP_MULL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM} md_op_e;
`else
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;
`endif
    state_e      state_q, state_d;
    logic        is_div_q, accept, en;
    logic [1:0]  operator_q, signed_mode_q;
    logic [31:0] op_a_q, op_b_q;
    logic [4:0]  rd_q;
    assign accept = (state_q == IDLE) && req_valid_i && !flush_i;
`ifdef BRQ_MULTDIV_ZERO_FASTPATH_EN
    logic        fast_req;
    logic [31:0] fast_res;
    assign fast_req = !data_ind_timing_i &&
                      ((req_operator_i inside {MD_OP_MULL, MD_OP_MULH}) ?
                       (req_op_a_i == '0 || req_op_b_i == '0) : (req_op_b_i == '0));
    assign fast_res = (operator_q == MD_OP_DIV) ? '1 : (operator_q == MD_OP_REM) ? op_a_q : '0;
`else
    logic unused_dit;
    assign unused_dit = data_ind_timing_i;
`endif
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            is_div_q       <= 1'b0;
            operator_q     <= '0;
            signed_mode_q  <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            rd_q           <= '0;
            imd_val_q_o[0] <= '0;
            imd_val_q_o[1] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_div_q      <= req_is_div_i;
                operator_q    <= req_operator_i;
                signed_mode_q <= req_signed_mode_i;
                op_a_q        <= req_op_a_i;
                op_b_q        <= req_op_b_i;
                rd_q          <= req_rd_i;
            end
            for (int i = 0; i < 2; i++)
                if (imd_val_we_i[i]) imd_val_q_o[i] <= imd_val_d_i[i];
        end
    end
    // The unit cannot be aborted: a flushed operation drains with enables held high.
    always_comb begin
        state_d            = state_q;
        en                 = 1'b0;
        multdiv_ready_id_o = 1'b0;
        rf_we_o            = 1'b0;
        rf_wdata_o         = '0;
        case (state_q)
            IDLE: begin
`ifdef BRQ_MULTDIV_ZERO_FASTPATH_EN
                state_d = accept ? (fast_req ? FAST : BUSY) : IDLE;
`else
                state_d = accept ? BUSY : IDLE;
`endif
            end
            BUSY: begin
                en                 = 1'b1;
                multdiv_ready_id_o = wb_ready_i;
                rf_we_o            = md_valid_i && wb_ready_i && !flush_i;
                rf_wdata_o         = rf_we_o ? md_result_i : '0;
                state_d            = (md_valid_i && wb_ready_i) ? IDLE : flush_i ? DRAIN : BUSY;
            end
            DRAIN: begin
                en                 = 1'b1;
                multdiv_ready_id_o = 1'b1;
                state_d            = md_valid_i ? IDLE : DRAIN;
            end
`ifdef BRQ_MULTDIV_ZERO_FASTPATH_EN
            FAST: begin
                rf_we_o    = wb_ready_i && !flush_i;
                rf_wdata_o = rf_we_o ? fast_res : '0;
                state_d    = (wb_ready_i || flush_i) ? IDLE : FAST;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    assign mult_en_o     = en && !is_div_q;
    assign mult_sel_o    = en && !is_div_q;
    assign div_en_o      = en && is_div_q;
    assign div_sel_o     = en && is_div_q;
    assign operator_o    = operator_q;
    assign signed_mode_o = signed_mode_q;
    assign op_a_o        = op_a_q;
    assign op_b_o        = op_b_q;
    assign rf_waddr_o    = rd_q;
    assign busy_o        = (state_q != IDLE);
    assign req_ready_o   = (state_q == IDLE);
endmodule
